serial_addsub: RTL and testbench

Bit-serial adder/subtractor that computes A+B or A−B over WIDTH clock cycles using a single full-adder cell and a registered carry. It is the sequential counterpart to the board-level combinational full-adder: operands come from the switch bank, and the result, carry and overflow drive LEDs and HEX displays. It sits between the switch/key input logic and the display logic, with a start/busy/done handshake to the controlling top level.

---
 rtl/serial_addsub_if.sv | 41 ++++
 rtl/serial_addsub.sv | 159 +++++++++++++++
 tb/tb_serial_addsub.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// serial_addsub_if
// ----------------
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
//
// Signals (all sampled/updated on the rising edge of the owner's clock):
//   start     controller -> unit   request a new operation (honoured only when idle)
//   sub       controller -> unit   0 = add, 1 = subtract; captured with start
//   a, b      controller -> unit   operands; captured with start
//   busy      unit -> controller   high while bits are being processed
//   done      unit -> controller   one-cycle pulse, result/cout/overflow valid
//   result    unit -> controller   sum or difference modulo 2^WIDTH
//   cout      unit -> controller   final carry (subtract: 1 = no borrow)
//   overflow  unit -> controller   two's-complement overflow
//
// Modports: master = controlling top level, slave = serial_addsub.

interface serial_addsub_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, overflow
  );

endinterface

// File: rtl/serial_addsub.sv
// serial_addsub
// -------------
// Bit-serial adder/subtractor. One full-adder cell and a registered carry
// process one operand bit per clock, LSB first, so an operation takes WIDTH
// shift cycles plus one DONE cycle.
//
// Subtraction is done as A + ~B + 1: B is inverted when captured and the
// carry register is seeded with 1.
//
// Ports:
//   clk      rising-edge system clock
//   reset_n  asynchronous active-low reset
//   bus      serial_addsub_if.slave (start/sub/a/b in; busy/done/result/
//            cout/overflow out, all driven from registers)

module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  serial_addsub_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  // Full-adder carry bit (majority of the three inputs).
  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  state_t           state_r;
  state_t           state_n;

  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic             accept_s;
  logic             step_s;
  logic             last_s;
  logic             sum_s;
  logic             cy_s;

  assign sum_s = fa_sum(sa_r[0], sb_r[0], carry_r);
  assign cy_s  = fa_carry(sa_r[0], sb_r[0], carry_r);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    step_s   = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          state_n  = SHIFT;
        end else begin
          state_n  = IDLE;
        end
      end
      SHIFT: begin
        step_s = 1'b1;
        if (cnt_r == LAST_BIT) begin
          last_s  = 1'b1;
          state_n = DONE;
        end else begin
          state_n = SHIFT;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Handshake outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_n == SHIFT);
      done_r <= (state_n == DONE);
    end
  end

  // Operand shift registers, carry, bit counter, result and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_r    <= '0;
      sb_r    <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      sa_r    <= bus.a;
      sb_r    <= bus.sub ? ~bus.b : bus.b;
      carry_r <= bus.sub;
      cnt_r   <= '0;
      res_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (step_s) begin
      // Sum bits enter at the MSB end, so after WIDTH steps bit 0 sits at LSB.
      res_r   <= {sum_s, res_r[WIDTH-1:1]};
      sa_r    <= {1'b0, sa_r[WIDTH-1:1]};
      sb_r    <= {1'b0, sb_r[WIDTH-1:1]};
      carry_r <= cy_s;
      if (last_s) begin
        // During the MSB step carry_r is the carry into the MSB.
        cout_r <= cy_s;
        ovf_r  <= carry_r ^ cy_s;
        cnt_r  <= '0;
      end else begin
        cnt_r  <= cnt_r + CW'(1);
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.result   = res_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub (WIDTH = 4): fixed vector table, exhaustive and
// random operations against an arithmetic reference model, start-held
// throughput, and asynchronous reset in the middle of an operation.

module tb_serial_addsub;

  localparam int W = 4;

  logic clk;
  logic reset_n;

  int total_cnt;
  int pass_cnt;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int sub;
    int r;
    int c;
    int o;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int ta, input int tb_, input int ts,
                                output int r, output int c, output int o);
    int m;
    int sa;
    int sb;
    int s;
    m  = 1 << W;
    sa = (ta >= m / 2) ? ta - m : ta;
    sb = (tb_ >= m / 2) ? tb_ - m : tb_;
    if (ts != 0) begin
      r = (ta - tb_ + m) % m;
      c = (ta >= tb_) ? 1 : 0;
      s = sa - sb;
    end else begin
      r = (ta + tb_) % m;
      c = (ta + tb_ >= m) ? 1 : 0;
      s = sa + sb;
    end
    o = (s > m / 2 - 1 || s < -(m / 2)) ? 1 : 0;
  endfunction

  // One operation; inputs (including start) are scrambled during SHIFT.
  task automatic check_op(input int ta, input int tb_, input int ts,
                          input int er, input int ec, input int eo,
                          input string tag);
    int lat;
    int nb;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(ta);
    bus.b     = W'(tb_);
    bus.sub   = 1'(ts);
    @(posedge clk);
    #1;
    lat = 0;
    nb  = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) nb++;
      bus.start = 1'($urandom_range(0, 1));
      bus.a     = W'($urandom_range(0, 15));
      bus.b     = W'($urandom_range(0, 15));
      bus.sub   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, " latency"}, lat, W);
    chk({tag, " busy cycles"}, nb, W);
    chk({tag, " busy at done"}, int'(bus.busy), 0);
    chk({tag, " result"}, int'(bus.result), er);
    chk({tag, " cout"}, int'(bus.cout), ec);
    chk({tag, " overflow"}, int'(bus.overflow), eo);
    @(posedge clk);
    #1;
    chk({tag, " done pulse width"}, int'(bus.done), 0);
    chk({tag, " result hold"}, int'(bus.result), er);
  endtask

  task automatic model_op(input int ta, input int tb_, input int ts, input string tag);
    int r;
    int c;
    int o;
    model(ta, tb_, ts, r, c, o);
    check_op(ta, tb_, ts, r, c, o, tag);
  endtask

  initial begin
    int ndone;
    int t_prev;

    total_cnt = 0;
    pass_cnt  = 0;

    vecs[0] = '{a: 5,  b: 3, sub: 0, r: 8,  c: 0, o: 1};
    vecs[1] = '{a: 3,  b: 5, sub: 1, r: 14, c: 0, o: 0};
    vecs[2] = '{a: 5,  b: 3, sub: 1, r: 2,  c: 1, o: 0};
    vecs[3] = '{a: 15, b: 1, sub: 0, r: 0,  c: 1, o: 0};
    vecs[4] = '{a: 7,  b: 1, sub: 0, r: 8,  c: 0, o: 1};
    vecs[5] = '{a: 0,  b: 0, sub: 1, r: 0,  c: 1, o: 0};
    vecs[6] = '{a: 8,  b: 1, sub: 1, r: 7,  c: 1, o: 1};
    vecs[7] = '{a: 0,  b: 8, sub: 1, r: 8,  c: 0, o: 1};

    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    reset_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset result", int'(bus.result), 0);
    chk("reset cout", int'(bus.cout), 0);
    chk("reset overflow", int'(bus.overflow), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle busy", int'(bus.busy), 0);

    for (int i = 0; i < 8; i++) begin
      check_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].r, vecs[i].c, vecs[i].o,
               $sformatf("vec%0d", i));
    end

    // Start held high: one completion every W+2 cycles, operands fixed.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(9);
    bus.b     = W'(4);
    bus.sub   = 1'b0;
    ndone  = 0;
    t_prev = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (t_prev >= 0) chk("throughput period", cyc - t_prev, W + 2);
        chk("throughput result", int'(bus.result), 13);
        t_prev = cyc;
      end
    end
    bus.start = 1'b0;
    chk("throughput done count", ndone, 5);
    repeat (8) @(posedge clk);

    // Asynchronous reset between edges, two cycles after acceptance.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(5);
    bus.b     = W'(3);
    bus.sub   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midreset busy", int'(bus.busy), 0);
    chk("midreset done", int'(bus.done), 0);
    chk("midreset result", int'(bus.result), 0);
    chk("midreset cout", int'(bus.cout), 0);
    chk("midreset overflow", int'(bus.overflow), 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("midreset no done", int'(bus.done), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    check_op(2, 2, 0, 4, 0, 0, "post-reset");

    // Exhaustive sweep of a, b, sub.
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          model_op(x, y, s, $sformatf("exh a=%0d b=%0d sub=%0d", x, y, s));
        end
      end
    end

    // Random operations.
    for (int n = 0; n < 40; n++) begin
      int ra;
      int rb;
      int rs;
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      rs = int'($urandom_range(0, 1));
      model_op(ra, rb, rs, $sformatf("rnd a=%0d b=%0d sub=%0d", ra, rb, rs));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
